// File: rtl/tff_toggle_arbiter_if.sv
// Handshake bundle between the requesters (master) and tff_toggle_arbiter (slave).
// Defining TFF_ARB_LOCK_EN adds the lock input for repeated toggling while granted.
interface tff_toggle_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] tmask;
    logic                  clr;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  busy;
`ifdef TFF_ARB_LOCK_EN
    logic                  lock;

    modport master (output req, tmask, clr, lock, input gnt, q, busy);
    modport slave  (input req, tmask, clr, lock, output gnt, q, busy);
`else
    modport master (output req, tmask, clr, input gnt, q, busy);
    modport slave  (input req, tmask, clr, output gnt, q, busy);
`endif
endinterface

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter that lets NREQ requesters XOR their toggle masks into one shared T-FF bank.
// Optional TFF_ARB_LOCK_EN: while lock and req[winner] stay high, the bank keeps toggling every edge.
module tff_toggle_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    tff_toggle_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, WAIT} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_win;
    logic [NREQ-1:0]  r_gnt;
    logic [WIDTH-1:0] r_q;
    logic             r_busy;

    logic [PW-1:0]    w_pick;
    logic [PW-1:0]    w_pick_nxt;
    logic [WIDTH-1:0] w_mask;
    logic             w_win_req;
    logic             w_relock;

    // Scan from the farthest offset down so the nearest requester at/after r_ptr wins.
    always_comb begin
        w_pick = r_ptr;
        for (int off = NREQ - 1; off >= 0; off--) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(r_ptr) + off) % NREQ);
            if (bus.req[idx]) w_pick = idx;
        end
    end

    assign w_pick_nxt = (w_pick == PW'(NREQ - 1)) ? '0 : w_pick + PW'(1);
    assign w_mask     = bus.tmask[r_win*WIDTH +: WIDTH];
    assign w_win_req  = bus.req[r_win];

`ifdef TFF_ARB_LOCK_EN
    assign w_relock = bus.lock & w_win_req;
`else
    assign w_relock = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                        r_win   <= w_pick;
                        r_ptr   <= w_pick_nxt;
                        r_state <= APPLY;
                        r_busy  <= 1'b1;
                    end
                end
                APPLY: begin
                    r_q <= r_q ^ w_mask;
                    if (w_win_req) begin
                        r_state <= WAIT;
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (w_relock) r_q <= r_q ^ w_mask;
                    if (!w_win_req) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
            // Clear beats any toggle on the same edge; the handshake itself is untouched.
            if (bus.clr) r_q <= '0;
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.q    = r_q;
    assign bus.busy = r_busy;
endmodule

// File: doc/tff_toggle_arbiter.md
Name: tff_toggle_arbiter

Overview:
- Round-robin arbiter sharing one WIDTH-bit toggle-register bank between NREQ requesters.
- The bank is a row of T flip-flops. Each requester presents a toggle mask. On its grant, exactly one XOR of that mask into the bank is applied.
- Four-phase req/gnt handshake.
- Sits between independent control agents and the shared T-FF status/pattern register.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, width of shared toggle bank

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request, level, held until gnt seen then dropped
- tmask  input  NREQ*WIDTH  per-requester toggle mask, requester i at bits [i*WIDTH +: WIDTH]
- clr  input  1  synchronous clear of bank, highest priority
- gnt  output  NREQ  one-hot grant, registered
- q  output  WIDTH  shared toggle bank state
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, q=0, busy=0, rr pointer=0. Reset mid-handshake aborts it; any pending toggle is discarded.
- States: IDLE, APPLY, WAIT.
- IDLE:
  - If |req, select the winner by round-robin starting at the pointer: first i in order ptr, ptr+1, ..., mod NREQ with req[i]=1.
  - On the next edge: gnt[winner]=1, state=APPLY, ptr=(winner+1) mod NREQ.
  - If req=0, stay in IDLE.
- APPLY (exactly one cycle):
  - At the exiting edge, q <= q ^ tmask[winner], using the mask sampled at that edge.
  - If req[winner] is still 1, go to WAIT with gnt held.
  - If req[winner] is already 0, go to IDLE and gnt=0.
- WAIT:
  - gnt stays high, no further toggles.
  - When req[winner]=0 is sampled, gnt=0 and state=IDLE.
- After any grant, at least one IDLE cycle with gnt=0 precedes the next grant.
- Latency: req sampled at edge k in IDLE gives gnt at edge k, and q updated at edge k+1.
- Requests other than the winner are ignored until IDLE. There is no queuing beyond the live req level.
- clr=1 at an edge: q <= 0. This overrides a simultaneous APPLY toggle; that toggle is lost, but the handshake still completes normally. clr does not affect state, gnt or ptr.
- Pointer wraps from NREQ-1 to 0.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants.
- gnt is always one-hot or zero. The winner's index is held in a register.

Optional Feature:
- Macro TFF_ARB_LOCK_EN adds input port lock (1 bit).
- With macro, in APPLY or WAIT:
  - If lock=1 and req[winner]=1, the grant is retained and q toggles by tmask[winner] at every edge (repeated T-FF toggling).
  - The state goes to IDLE only when req[winner] drops. lock is ignored in IDLE. clr still has priority.
- Without macro: the port is absent and exactly one toggle is applied per grant.

Test Plan:
- Reset: rst=0 with req=4'b1111 -> gnt=0, q=0, busy=0. Release rst, then at the next edge gnt=4'b0001.
- Single request: req[2]=1, tmask[2]=8'hA5 held until gnt -> gnt=4'b0100 one edge later, q=8'hA5 one edge after that. Drop req -> gnt=0, busy=0. Repeat -> q=8'h00.
- Round-robin: req=4'b1111 held high, each requester drops req one cycle after its grant -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
- clr collision: clr=1 on the APPLY edge with q=8'h0F, tmask=8'hF0 -> q=8'h00, and gnt still released on req drop.
- Async reset mid-WAIT: rst=0 while gnt=4'b0010 -> gnt=0 and q=0 immediately, state=IDLE, ptr=0.
- TFF_ARB_LOCK_EN: lock=1, req[0]=1 for 3 cycles, tmask[0]=8'h01, q=0 -> q sequence 01,00,01. Drop req -> gnt=0.
